data_mem_responder: RTL

//  Data-memory responder on the far side of the CPU memory-stage load/store port.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_lane_align.sv | 61 ++++++
 rtl/data_mem_responder.sv | 119 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: RV32I funct3 codes, FSM states
// and the latched request record.
package mem_pkg;

    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} mem_state_t;

    typedef struct packed {
        logic              write;
        logic [2:0]        funct3;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: store byte enables and replicated
// store data, sign/zero-extended load data, and the misalign/illegal flag.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic        isWrite,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdWord,
    output logic [3:0]  byteEn,
    output logic [31:0] wdataLanes,
    output logic [31:0] loadData,
    output logic        badAccess
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel    = rdWord[{addrLo, 3'b000} +: 8];
        halfSel    = addrLo[1] ? rdWord[31:16] : rdWord[15:0];
        byteEn     = '0;
        wdataLanes = '0;
        loadData   = '0;
        badAccess  = 1'b0;

        // Store data is replicated across lanes; byte enables pick the target lane.
        case (funct3[1:0])
            2'b00: begin
                byteEn     = 4'b0001 << addrLo;
                wdataLanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                byteEn     = addrLo[1] ? 4'b1100 : 4'b0011;
                wdataLanes = {2{wdata[15:0]}};
                badAccess  = addrLo[0];
            end
            2'b10: begin
                byteEn     = 4'b1111;
                wdataLanes = wdata;
                badAccess  = |addrLo;
            end
            default: badAccess = 1'b1;
        endcase

        // Unsigned variants exist only for byte/half loads.
        if (funct3[2] && (isWrite || funct3[1]))
            badAccess = 1'b1;

        case (funct3)
            F3_B:    loadData = {{24{byteSel[7]}}, byteSel};
            F3_BU:   loadData = {24'd0, byteSel};
            F3_H:    loadData = {{16{halfSel[15]}}, halfSel};
            F3_HU:   loadData = {16'd0, halfSel};
            F3_W:    loadData = rdWord;
            default: loadData = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES of latency,
// RV32I sized loads/stores into a word array, response held until accepted.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 1024,
    parameter int WAIT_CYCLES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int IdxW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [ADDRESS_WIDTH:0] ByteLimit = (ADDRESS_WIDTH + 1)'(4 * DEPTH_WORDS);

    mem_state_t  state, nextState;
    logic [3:0]  waitCnt;
    mem_req_t    reqIn, reqQ, curReq;
    logic [31:0] rspData;
    logic        rspErr;

    logic [31:0] mem [DEPTH_WORDS];
    logic [IdxW-1:0] wordIdx;
    logic [31:0] rdWord, wdataLanes, loadData;
    logic [3:0]  byteEn;
    logic        badAccess, outOfRange, reqErr;

    assign reqIn = '{write: req_write, funct3: req_funct3,
                     addr: MEM_AW'(req_addr), wdata: MEM_DW'(req_wdata)};

    // In IDLE the aligner judges the incoming request; afterwards it serves the latched one.
    assign curReq     = (state == IDLE) ? reqIn : reqQ;
    assign outOfRange = {1'b0, req_addr} >= ByteLimit;
    assign reqErr     = badAccess || outOfRange;
    assign wordIdx    = curReq.addr[IdxW+1:2];
    assign rdWord     = mem[wordIdx];

    mem_lane_align uAlign (
        .isWrite    (curReq.write),
        .funct3     (curReq.funct3),
        .addrLo     (curReq.addr[1:0]),
        .wdata      (curReq.wdata),
        .rdWord     (rdWord),
        .byteEn     (byteEn),
        .wdataLanes (wdataLanes),
        .loadData   (loadData),
        .badAccess  (badAccess)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (req_valid) begin
                if (reqErr)                nextState = RESP;
                else if (WAIT_CYCLES == 0) nextState = ACCESS;
                else                       nextState = WAIT;
            end
            WAIT:    if (waitCnt == 4'd0) nextState = ACCESS;
            ACCESS:  nextState = RESP;
            RESP:    if (rsp_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt <= '0;
            reqQ    <= '0;
            rspData <= '0;
            rspErr  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    reqQ    <= reqIn;
                    waitCnt <= WaitInit;
                    rspData <= '0;
                    rspErr  <= reqErr;
                end
                WAIT:   if (waitCnt != 4'd0) waitCnt <= waitCnt - 4'd1;
                ACCESS: rspData <= reqQ.write ? 32'd0 : loadData;
                default: ;
            endcase
        end
    end

    // Storage is deliberately outside reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (state == ACCESS && reqQ.write) begin
            for (int b = 0; b < 4; b++)
                if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wdataLanes[8*b +: 8];
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_rdata = DATA_WIDTH'(rspData);
    assign rsp_err   = rspErr;

endmodule
